// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter
// and the round-robin pick logic reused by the read-side scheduler.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // True when an index of width w can address all n requesters.
    function automatic bit idw_fits(int n, int w);
        return (w >= 1) && ((1 << w) >= n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above
// start, wrapping modulo NREQ (NREQ need not be a power of two).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  start,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    if (!idw_fits(NREQ, IDW)) begin : g_bad_idw
        $error("rr_pick: IDW too narrow for NREQ");
    end

    logic [NREQ-1:0] rot;
    logic [IDW:0]    j;
    logic [IDW-1:0]  pos;
    logic [IDW:0]    sum;

    // Rotate so start sits at bit 0, take lowest set bit, map back.
    always_comb begin
        rot = '0;
        j   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = {1'b0, start} + (IDW+1)'(i);
            if (j >= NREQ_W) j = j - NREQ_W;
            rot[i] = req[j[IDW-1:0]];
        end
        pos = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (rot[i]) pos = IDW'(i);
        end
        sum = {1'b0, start} + {1'b0, pos};
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        idx   = sum[IDW-1:0];
        found = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ
// producers, with bounded bursts and gapless handover.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int IDW       = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       accept,
    output logic [IDW-1:0]        owner,
    output logic                  busy,
    input  logic                  fifo_full,
    output logic                  fifo_write,
    output logic [WIDTH-1:0]      fifo_data_in
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

    logic            own_req;
    logic            acc_any;
    logic            last_beat;
    logic            rel;
    logic [IDW-1:0]  next_ptr;
    logic [IDW-1:0]  pick_start;
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;

    assign gnt = gnt_q;

    // Per-cycle accept, FIFO write strobe and data mux for the owner.
    always_comb begin
        busy         = (state_q == OWN);
        own_req      = |(gnt_q & req);
        acc_any      = busy & own_req & ~fifo_full;
        accept       = acc_any ? (gnt_q & req) : '0;
        fifo_write   = acc_any;
        owner        = owner_q;
        fifo_data_in = '0;
        if (busy) begin
            for (int i = 0; i < NREQ; i++) begin
                if (owner_q == IDW'(i)) begin
                    fifo_data_in = req_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Release detection and the search start for re-arbitration.
    always_comb begin
        last_beat  = acc_any && (burst_cnt_q == CW'(MAX_BURST - 1));
        rel        = busy && (!own_req || last_beat);
        next_ptr   = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        pick_start = busy ? next_ptr : rr_ptr_q;
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant FSM: acquire from idle, count burst, hand over on release.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = OWN;
                    owner_d     = pick_idx;
                    gnt_d       = NREQ'(1) << pick_idx;
                    burst_cnt_d = '0;
                end
            end
            OWN: begin
                if (rel) begin
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                        gnt_d   = NREQ'(1) << pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (acc_any) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter (4-way instance) plus a
// short hand sequence on a 3-way instance for the modulo wrap.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  accept;
    logic [1:0]  owner;
    logic        busy;
    logic        full;
    logic        wr;
    logic [7:0]  din;

    logic [2:0]  req3;
    logic [23:0] data3;
    logic [2:0]  gnt3;
    logic [2:0]  acc3;
    logic [1:0]  owner3;
    logic        busy3;
    logic        full3;
    logic        wr3;
    logic [7:0]  din3;

    int total = 0;
    int bad   = 0;

    logic [7:0] dval [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    fifo_wr_arbiter #(
        .NREQ      (4),
        .WIDTH     (8),
        .MAX_BURST (4)
    ) u4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .accept       (accept),
        .owner        (owner),
        .busy         (busy),
        .fifo_full    (full),
        .fifo_write   (wr),
        .fifo_data_in (din)
    );

    fifo_wr_arbiter #(
        .NREQ      (3),
        .WIDTH     (8),
        .MAX_BURST (4)
    ) u3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req3),
        .req_data     (data3),
        .gnt          (gnt3),
        .accept       (acc3),
        .owner        (owner3),
        .busy         (busy3),
        .fifo_full    (full3),
        .fifo_write   (wr3),
        .fifo_data_in (din3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       rst_n;
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic [3:0] acc;
        logic       wr;
        logic       busy;
        logic [1:0] own;
    } vec_t;

    vec_t tv[$];

    task automatic v(int n, logic r, logic [3:0] rq, logic f,
                     logic [3:0] g, logic [3:0] a, logic w,
                     logic b, logic [1:0] o);
        vec_t t;
        t.n = n; t.rst_n = r; t.req = rq; t.full = f;
        t.gnt = g; t.acc = a; t.wr = w; t.busy = b; t.own = o;
        tv.push_back(t);
    endtask

    task automatic chk(string nm, int row, logic [31:0] act,
                       logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h want=%0h",
                     nm, row, act, exp);
        end
    endtask

    function automatic logic [7:0] edata(logic b, logic [1:0] o);
        return b ? dval[o] : 8'h00;
    endfunction

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        full     = 1'b0;
        req3     = '0;
        full3    = 1'b0;
        req_data = {dval[3], dval[2], dval[1], dval[0]};
        data3    = {dval[2], dval[1], dval[0]};

        // reset
        v(1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // single producer: 10 gapless writes, self re-grant
        v(1, 1, 4'b0001, 0, 4'b0000, 4'b0000, 0, 0, 0);
        v(10,1, 4'b0001, 0, 4'b0001, 4'b0001, 1, 1, 0);
        v(1, 1, 4'b0000, 0, 4'b0001, 4'b0000, 0, 1, 0);
        v(1, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // all requesting: 4 accepts each, rotating
        v(1, 0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
        v(1, 1, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
        v(4, 1, 4'b1111, 0, 4'b0001, 4'b0001, 1, 1, 0);
        v(4, 1, 4'b1111, 0, 4'b0010, 4'b0010, 1, 1, 1);
        v(4, 1, 4'b1111, 0, 4'b0100, 4'b0100, 1, 1, 2);
        v(4, 1, 4'b1111, 0, 4'b1000, 4'b1000, 1, 1, 3);
        v(1, 1, 4'b1111, 0, 4'b0001, 4'b0001, 1, 1, 0);
        // async reset mid-burst, then fresh grant to producer 3
        v(1, 0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0);
        v(1, 1, 4'b1000, 0, 4'b0000, 4'b0000, 0, 0, 0);
        v(1, 1, 4'b1000, 0, 4'b1000, 4'b1000, 1, 1, 3);
        v(1, 1, 4'b0000, 0, 4'b1000, 4'b0000, 0, 1, 3);
        v(1, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // full stall on owner 2 with two beats done
        v(1, 1, 4'b0100, 0, 4'b0000, 4'b0000, 0, 0, 0);
        v(2, 1, 4'b0100, 0, 4'b0100, 4'b0100, 1, 1, 2);
        v(5, 1, 4'b1100, 1, 4'b0100, 4'b0000, 0, 1, 2);
        v(2, 1, 4'b1100, 0, 4'b0100, 4'b0100, 1, 1, 2);
        v(1, 1, 4'b1000, 0, 4'b1000, 4'b1000, 1, 1, 3);
        v(1, 1, 4'b0000, 0, 4'b1000, 4'b0000, 0, 1, 3);
        v(1, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // early drop by owner 1; pointer at 2 picks 3 over 0
        v(1, 1, 4'b0010, 0, 4'b0000, 4'b0000, 0, 0, 0);
        v(1, 1, 4'b1011, 0, 4'b0010, 4'b0010, 1, 1, 1);
        v(1, 1, 4'b1001, 0, 4'b0010, 4'b0000, 0, 1, 1);
        v(1, 1, 4'b1001, 0, 4'b1000, 4'b1000, 1, 1, 3);
        v(1, 1, 4'b0000, 0, 4'b1000, 4'b0000, 0, 1, 3);
        v(1, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);

        for (int r = 0; r < tv.size(); r++) begin
            for (int k = 0; k < tv[r].n; k++) begin
                @(negedge clk);
                rst_n = tv[r].rst_n;
                req   = tv[r].req;
                full  = tv[r].full;
                #1;
                chk("gnt",    r, 32'(gnt),    32'(tv[r].gnt));
                chk("accept", r, 32'(accept), 32'(tv[r].acc));
                chk("write",  r, 32'(wr),     32'(tv[r].wr));
                chk("busy",   r, 32'(busy),   32'(tv[r].busy));
                chk("data",   r, 32'(din),
                    32'(edata(tv[r].busy, tv[r].own)));
                chk("onehot", r, 32'($onehot0(gnt)), 32'd1);
                if (tv[r].busy || !tv[r].rst_n) begin
                    chk("owner", r, 32'(owner), 32'(tv[r].own));
                end
            end
        end

        // three producers: owner 2 releases, pointer wraps to 0
        @(negedge clk);
        req3 = 3'b100;
        #1;
        chk("n3_idle_gnt", 100, 32'(gnt3), 32'h0);
        @(negedge clk);
        #1;
        chk("n3_gnt2",  101, 32'(gnt3),   32'b100);
        chk("n3_acc2",  101, 32'(acc3),   32'b100);
        chk("n3_own2",  101, 32'(owner3), 32'd2);
        chk("n3_dat2",  101, 32'(din3),   32'h33);
        @(negedge clk);
        req3 = 3'b001;
        #1;
        chk("n3_drop_gnt", 102, 32'(gnt3), 32'b100);
        chk("n3_drop_wr",  102, 32'(wr3),  32'd0);
        @(negedge clk);
        #1;
        chk("n3_gnt0", 103, 32'(gnt3),   32'b001);
        chk("n3_acc0", 103, 32'(acc3),   32'b001);
        chk("n3_own0", 103, 32'(owner3), 32'd0);
        chk("n3_dat0", 103, 32'(din3),   32'h11);
        @(negedge clk);
        req3 = 3'b000;
        #1;
        chk("n3_rel_busy", 104, 32'(busy3), 32'd1);
        @(negedge clk);
        #1;
        chk("n3_idle_end", 105, 32'(gnt3), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
